// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: source-domain scheduler for a 4-phase req/ack CDC channel.
// Several requesters share one multi-bit crossing through round-robin arbitration.
// The granted word is held on xfer_data while xfer_req/ack run through the full
// req-high / ack-high / req-low / ack-low sequence.
// Optional feature: define CDC_HS_TIMEOUT_EN to build the ack-wait timeout (err).
//
// Handshake on the requester side: a requester raises req_valid[i] and holds it
// together with its slice of req_data until it sees req_ready[i] high for one
// cycle. The word is captured in that cycle. Dropping req_valid before the grant
// withdraws the request.
module cdc_hs_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk_src,
    input  logic                     Rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     xfer_req,
    output logic [WIDTH-1:0]         xfer_data,
    output logic [$clog2(NREQ)-1:0]  xfer_src,
    input  logic                     xfer_ack_async,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               fsm_state
);

    localparam int IDXW = $clog2(NREQ);
    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;
    logic [IDXW-1:0]        ptr;
    logic [IDXW-1:0]        ptr_next;
    logic [IDXW-1:0]        win;
    logic                   found;
    logic                   grant;
    logic                   tmo;
    logic                   timed_out;
    logic [IDXW:0]          cand_sum;
    logic [IDXW-1:0]        cand;
    logic [IDXW:0]          ptr_sum;

    assign ack_sync  = sync_q[SYNC_STAGES-1];
    assign fsm_state = state;

    // A grant needs an idle channel with no stale ack visible. Reset gates the
    // pulse so no output is high while Rst is asserted.
    assign grant = (state == IDLE) && !ack_sync && found && !Rst;

    // Ack level synchronizer: the ack is shifted in from the LSB side.
    always_ff @(posedge clk_src or posedge Rst) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack_async};
        end
    end

    // Round-robin search from the pointer upward with wrap, and the pointer
    // value that follows a grant to 'win'.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr} + (IDXW+1)'(k);
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            cand = cand_sum[IDXW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_sum = {1'b0, win} + (IDXW+1)'(1);
        if (ptr_sum == NREQ_W) begin
            ptr_next = '0;
        end else begin
            ptr_next = ptr_sum[IDXW-1:0];
        end
    end

    // Capture the granted word and index; they only move in a grant cycle.
    always_ff @(posedge clk_src or posedge Rst) begin
        if (Rst) begin
            xfer_data <= '0;
            xfer_src  <= '0;
            ptr       <= '0;
        end else if (grant) begin
            xfer_data <= req_data[int'(win)*WIDTH +: WIDTH];
            xfer_src  <= win;
            ptr       <= ptr_next;
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

    logic [CW-1:0] wait_cnt;

    // The counter restarts on every state change and advances while in REQ_HI;
    // it stops at TIMEOUT because REQ_HI is left in that cycle.
    always_ff @(posedge clk_src or posedge Rst) begin
        if (Rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (state == REQ_HI && wait_cnt != CW'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign tmo = (state == REQ_HI) && !ack_sync && (wait_cnt == CW'(TIMEOUT));

    // Remember an abandoned transfer so REQ_LO finishes without a done pulse.
    always_ff @(posedge clk_src or posedge Rst) begin
        if (Rst) begin
            timed_out <= 1'b0;
        end else if (tmo) begin
            timed_out <= 1'b1;
        end else if (state == IDLE) begin
            timed_out <= 1'b0;
        end
    end
`else
    // No timeout logic: REQ_HI waits for the ack indefinitely.
    assign tmo       = 1'b0 & (TIMEOUT > 0);
    assign timed_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_src or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the 4-phase sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_sync || tmo) begin
                    state_next = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state; req_ready is the one-hot grant pulse.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
        xfer_req = (state == REQ_HI);
        busy     = (state != IDLE);
        done     = (state == REQ_LO) && !ack_sync && !timed_out;
        err      = tmo;
    end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Testbench for cdc_hs_arbiter (NREQ=4, WIDTH=8, SYNC_STAGES=2).
// The destination is a loopback whose ack follows xfer_req after 0..3 cycles,
// or a forced ack level for the stale-ack and timeout scenarios.
module tb_cdc_hs_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef CDC_HS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              xfer_req;
    logic [WIDTH-1:0]  xfer_data;
    logic [1:0]        xfer_src;
    logic              xfer_ack_async;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        fsm_state;

    cdc_hs_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT(TMO)
    ) dut (
        .clk_src(clk), .Rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
        .xfer_src(xfer_src), .xfer_ack_async(xfer_ack_async), .busy(busy),
        .done(done), .err(err), .fsm_state(fsm_state)
    );

    // ---------------- clock / destination model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       ack_ovr_en;
    logic       ack_ovr_val;
    logic [2:0] ack_pipe;
    int         ack_d;
    logic       ack_line;

    always @(posedge clk) ack_pipe <= {ack_pipe[1:0], xfer_req};

    always_comb begin
        ack_line = xfer_req;
        if (ack_d == 1) ack_line = ack_pipe[0];
        if (ack_d == 2) ack_line = ack_pipe[1];
        if (ack_d == 3) ack_line = ack_pipe[2];
    end

    assign xfer_ack_async = ack_ovr_en ? ack_ovr_val : ack_line;

    // ---------------- scoreboard / reference model ----------------
    int         n_checks;
    int         n_errors;
    logic [WIDTH-1:0] exp_q[$];
    int         grant_log[$];
    bit         pend[NREQ];
    logic [WIDTH-1:0] pdata[NREQ];
    int         m_ptr;
    bit         m_busy;
    int         m_k;
    int         m_d;
    int         m_src;
    bit         rand_en;
    bit         hold_all;
    int         done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (hold_all && !pend[i]) begin
                pend[i]  = 1'b1;
                pdata[i] = WIDTH'($urandom);
            end
            if (rand_en && !pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]  = 1'b1;
                pdata[i] = WIDTH'($urandom);
            end else if (rand_en && pend[i] && $urandom_range(0, 31) == 0) begin
                pend[i] = 1'b0;
            end
            req_valid[i] = pend[i];
            req_data[i*WIDTH +: WIDTH] = pend[i] ? pdata[i] : WIDTH'($urandom);
        end
    endtask

    // Compare one cycle of DUT outputs with the transaction-level model.
    task automatic sample_check();
        int w;
        if (done === 1'b1) done_cnt++;
        check("err_low", err, 0);
        if (!m_busy) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) begin
                int idx;
                idx = (m_ptr + j) % NREQ;
                if (w < 0 && pend[idx]) w = idx;
            end
            check("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
            check("idle_busy", busy, 0);
            check("idle_xfer_req", xfer_req, 0);
            check("idle_done", done, 0);
            if (w >= 0) begin
                exp_q.push_back(pdata[w]);
                grant_log.push_back(w);
                m_src  = w;
                m_ptr  = (w + 1) % NREQ;
                pend[w] = 1'b0;
                if (rand_en) ack_d = $urandom_range(0, 3);
                m_d    = ack_d;
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else begin
            m_k++;
            check("busy_req_ready", req_ready, 0);
            check("xfer_req", xfer_req, (m_k < 4 + m_d) ? 1 : 0);
            check("busy", busy, 1);
            check("done", done, (m_k == 6 + 2*m_d) ? 1 : 0);
            check("xfer_data", xfer_data, exp_q[0]);
            check("xfer_src", xfer_src, m_src);
            if (m_k == 6 + 2*m_d) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        sample_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_xfer_req"}, xfer_req, 0);
        check({tag, "_xfer_data"}, xfer_data, 0);
        check({tag, "_xfer_src"}, xfer_src, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_ptr  = 0;
        m_busy = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0; n_errors = 0; done_cnt = 0;
        rst = 1'b1; req_valid = '0; req_data = '0;
        ack_ovr_en = 1'b0; ack_ovr_val = 1'b0; ack_d = 0;
        rand_en = 1'b0; hold_all = 1'b0; m_ptr = 0; m_busy = 1'b0; m_k = 0; m_d = 0; m_src = 0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; pdata[i] = '0; end

        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single transfer: requester 2 sends 0xA5, loopback ack 2 cycles late.
        ack_d = 2; done_cnt = 0;
        pend[2] = 1'b1; pdata[2] = 8'hA5;
        for (int i = 0; i < 60 && !(grant_log.size() == 1 && !m_busy); i++) step();
        check("t1_grants", grant_log.size(), 1);
        check("t1_src", grant_log[0], 2);
        check("t1_done_count", done_cnt, 1);
        check("t1_idle", m_busy, 0);

        // Fairness: all requesters held high, zero-delay loopback.
        do_reset("t2_pre");
        grant_log.delete(); ack_d = 0; hold_all = 1'b1;
        for (int i = 0; i < 200 && !(grant_log.size() >= 8 && !m_busy); i++) step();
        check("t2_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t2_order%0d", i), grant_log[i], i % 4);
        for (int i = 0; i < 200 && !(grant_log.size() >= 10 && m_busy && m_k >= 2); i++) step();
        check("t2_mid", grant_log.size(), 10);
        do_reset("t2_rst");
        grant_log.delete();
        for (int i = 0; i < 200 && !(grant_log.size() >= 4 && !m_busy); i++) step();
        check("t2_restart_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_restart%0d", i), grant_log[i], i);
        hold_all = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // Reset mid-handshake with 0x3C on the channel, then a new request.
        do_reset("t3_pre");
        ack_d = 1; grant_log.delete();
        pend[1] = 1'b1; pdata[1] = 8'h3C;
        for (int i = 0; i < 40 && !(m_busy && m_k >= 2); i++) step();
        check("t3_in_req_hi", xfer_req, 1);
        check("t3_captured", xfer_data, 8'h3C);
        do_reset("t3_rst");
        grant_log.delete();
        pend[3] = 1'b1; pdata[3] = 8'h5A;
        for (int i = 0; i < 60 && !(grant_log.size() == 1 && !m_busy); i++) step();
        check("t3_new_grants", grant_log.size(), 1);
        check("t3_new_src", grant_log[0], 3);

        // Stale ack: destination holds ack=1 through and after reset. Requester 0
        // is raised once the held ack has reached the synchronizer output.
        ack_ovr_en = 1'b1; ack_ovr_val = 1'b1; ack_d = 0;
        do_reset("t4_pre");
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001; req_data = {24'h0, 8'h77};
            @(negedge clk);
            check("t4_blocked", req_ready, 0);
            check("t4_blocked_busy", busy, 0);
        end
        @(posedge clk); #1;
        ack_ovr_en = 1'b0;
        @(negedge clk);
        check("t4_rel0", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_rel1", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_grant", req_ready, 4'b0001);
        exp_q.push_back(8'h77); grant_log.push_back(0);
        m_src = 0; m_ptr = 1; m_busy = 1'b1; m_k = 0; m_d = 0;
        for (int i = 0; i < 40 && m_busy; i++) step();
        check("t4_finished", m_busy, 0);

        // Randomized traffic with varying ack delay and withdrawn requests.
        grant_log.delete();
        rand_en = 1'b1;
        for (int i = 0; i < 600; i++) step();
        rand_en = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int i = 0; i < 40 && m_busy; i++) step();
        check("rand_drained", m_busy, 0);
        check("rand_active", (grant_log.size() > 20) ? 1 : 0, 1);

`ifdef CDC_HS_TIMEOUT_EN
        // Timeout: ack never returns; err 16 cycles after REQ_HI entry.
        ack_ovr_en = 1'b1; ack_ovr_val = 1'b0; done_cnt = 0;
        @(posedge clk); #1;
        req_valid = 4'b0100; req_data = {8'h00, 8'h99, 16'h0000};
        @(negedge clk);
        check("t6_grant", req_ready, 4'b0100);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check($sformatf("t6_err%0d", k), err, (k == 17) ? 1 : 0);
            check($sformatf("t6_req%0d", k), xfer_req, (k <= 17) ? 1 : 0);
            check($sformatf("t6_busy%0d", k), busy, (k <= 18) ? 1 : 0);
            check($sformatf("t6_data%0d", k), xfer_data, 8'h99);
            check($sformatf("t6_done%0d", k), done, 0);
        end
        ack_ovr_en = 1'b0;
        m_ptr = 3;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
